// File: rtl/b3_serial_adder.sv
// Serial base-3 adder: one digit per clock through a single one-digit
// adder cell, with a soc/eoc request handshake and illegal-digit detection.
//
// Handshake: the requester raises soc (level) and holds x/y stable while
// soc=1. The block answers by dropping eoc while it works and raising it
// again when s/cout/err are valid. The result then holds until soc is
// seen low, so a soc held high after completion never starts a second add.

// One base-3 digit adder: sum = (a+b+cin) mod 3, cout = (a+b+cin) >= 3.
module b3_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);
    logic [2:0] total;

    // Add the two digits and the carry, then fold back into the range 0..2.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {2'b00, cin};
        sum   = total[1:0];
        cout  = 1'b0;
        if (total >= 3'd3) begin
            sum  = 2'(total - 3'd3);
            cout = 1'b1;
        end
    end
endmodule

module b3_serial_adder #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic           soc,
    input  logic [2*N-1:0] x,
    input  logic [2*N-1:0] y,
    output logic           eoc,
    output logic [2*N-1:0] s,
    output logic           cout,
    output logic           err
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FAIL = 2'd2,
        WAIT = 2'd3
    } state_t;

    // State is kept as a named signal so checkers can bind to it directly.
    state_t          state;
    logic [2*N-1:0]  xr;
    logic [2*N-1:0]  yr;
    logic            carry;
    logic [CW-1:0]   cnt;

    logic [1:0]      digit_sum;
    logic            digit_cout;
    logic            illegal;
    logic [2*N+1:0]  s_shift;

    b3_adder u_digit (
        .a    (xr[1:0]),
        .b    (yr[1:0]),
        .cin  (carry),
        .sum  (digit_sum),
        .cout (digit_cout)
    );

    // Any digit encoded as 11 in either operand makes the request illegal.
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[2*i +: 2] == 2'b11 || y[2*i +: 2] == 2'b11) begin
                illegal = 1'b1;
            end
        end
    end

    // New sum digit enters at the top; after N shifts the LSD reaches [1:0].
    // Written as a wide shift so it also holds for N == 1.
    always_comb begin
        s_shift = {digit_sum, s} >> 2;
    end

    // Sequencer: latch operands, walk the carry chain, then hold the result.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            eoc   <= 1'b1;
            s     <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (soc) begin
                        eoc <= 1'b0;
                        if (illegal) begin
                            err   <= 1'b1;
                            s     <= '0;
                            cout  <= 1'b0;
                            state <= FAIL;
                        end else begin
                            xr    <= x;
                            yr    <= y;
                            carry <= 1'b0;
                            cnt   <= '0;
                            err   <= 1'b0;
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    s     <= s_shift[2*N-1:0];
                    xr    <= xr >> 2;
                    yr    <= yr >> 2;
                    carry <= digit_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        cout  <= digit_cout;
                        eoc   <= 1'b1;
                        state <= WAIT;
                    end
                end
                FAIL: begin
                    eoc   <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!soc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
